// File: rtl/dmem_ctrl.sv
// Single-port data-memory controller: one outstanding request, optional wait
// states, byte-lane writes and an address-range check against a fixed window.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic        mem_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_strb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        mem_err_o,
  output logic        busy_o
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wen_q, wen_d;
  logic            err_q, err_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      strb_q, strb_d;

  logic [31:0]     off;
  logic            in_range;
  logic [AW-1:0]   in_idx;
  logic [AW-1:0]   rd_idx;
  logic [3:0]      lane_we;
  logic [31:0]     ram_q [DEPTH_WORDS];
  logic [31:0]     rd_q;

  // Wrap-around of the subtraction lands far above SPAN, so it reads as out of range.
  assign off      = mem_addr_i - BASE_ADDR;
  assign in_range = {1'b0, off} < SPAN;
  assign in_idx   = off[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid_i) begin
          wen_d   = mem_wen_i;
          err_d   = !in_range;
          idx_d   = in_idx;
          wdata_d = mem_wdata_i;
          strb_d  = mem_strb_i;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  // The cycle before RESP is either the accept cycle (index from the bus) or the last wait cycle.
  assign rd_idx = (state_q == S_IDLE) ? in_idx : idx_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = (state_q == S_RESP) && wen_q && !err_q && strb_q[gi] && !rst_i;
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) ram_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end
    rd_q <= ram_q[rd_idx];
  end

  assign mem_done_o  = (state_q == S_RESP);
  assign mem_err_o   = mem_done_o && err_q;
  assign mem_rdata_o = (mem_done_o && !err_q && !wen_q) ? rd_q : 32'h0;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in the internal data RAM (power of two).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_2000, giving the byte address of word 0 (aligned to DEPTH_WORDS*4).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 0, giving the extra wait states inserted before each response (0..15).
REQ-004 clk_i  input  1  The single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  Reset; asynchronous and active-high.
REQ-006 mem_valid_i  input  1  Request strobe from the core; one-cycle pulse per access.
REQ-007 mem_wen_i  input  1  1 = write, 0 = read; sampled with mem_valid_i.
REQ-008 mem_addr_i  input  32  Byte address; sampled with mem_valid_i.
REQ-009 mem_wdata_i  input  32  Write data, byte lanes aligned to the word; sampled with mem_valid_i.
REQ-010 mem_strb_i  input  4  Byte-write enables, bit n = byte lane n; sampled with mem_valid_i.
REQ-011 mem_rdata_o  output  32  Read data; valid only in the mem_done_o cycle.
REQ-012 mem_done_o  output  1  One-cycle completion pulse per accepted request.
REQ-013 mem_err_o  output  1  Asserted with mem_done_o when the access was out of range.
REQ-014 busy_o  output  1  High from the cycle after acceptance up to and including the done cycle.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; reset state IDLE.
REQ-016 In IDLE, mem_valid_i=1 SHALL latch addr/wen/wdata/strb and move to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-017 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; at 0 the FSM moves to RESP.
REQ-018 In RESP, mem_done_o SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-019 Latency: mem_done_o SHALL assert exactly WAIT_CYCLES+1 cycles after the mem_valid_i cycle (WAIT_CYCLES=0: the very next cycle).
REQ-020 mem_valid_i while not in IDLE SHALL be ignored (no latch, no response); a request in the same cycle as RESP SHALL also be ignored.
REQ-021 In-range check: mem_addr_i - BASE_ADDR < DEPTH_WORDS*4 (unsigned 32-bit, wrap-around yields out of range); word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
REQ-022 In-range write: each byte lane with strb bit 1 SHALL be written at the rising edge ending the RESP cycle; other lanes unchanged; strb=0 writes nothing and still completes.
REQ-023 In-range read: mem_rdata_o SHALL equal the full word at the index in the RESP cycle, reflecting all previously completed writes.
REQ-024 Out-of-range access: no RAM write; mem_rdata_o=0; mem_err_o=1 in the RESP cycle.
REQ-025 mem_rdata_o, mem_err_o SHALL be 0 in every cycle where mem_done_o=0.
REQ-026 A write's data SHALL be visible to a read accepted in the cycle immediately after that write's done.

Reset
REQ-027 On rst_i=1: FSM to IDLE, counter 0, mem_done_o=0, mem_err_o=0, mem_rdata_o=0, busy_o=0, latched request cleared.
REQ-028 RAM contents SHALL NOT be reset; content after power-up is undefined.
REQ-029 Reset during WAIT or RESP SHALL abort the access: no done pulse and, for a write, no RAM update.
REQ-030 The first request SHALL be accepted no earlier than the first rising edge after rst_i deasserts.

Verification
REQ-031 WAIT_CYCLES=0: write 32'hDEADBEEF strb 4'hF to 32'h2000, then read 32'h2000 -> each done one cycle after valid, read data 32'hDEADBEEF, err 0.
REQ-032 Byte strobes: write 32'h11223344 strb F to 32'h2004, then 32'hAABBCCDD strb 4'b0101, then read -> 32'h11BB33DD.
REQ-033 WAIT_CYCLES=3: read request at cycle t -> busy_o high t+1..t+4, done only at t+4; valid pulses at t+1 and t+4 are ignored (exactly one done).
REQ-034 Out of range: read 32'h1FFC and write 32'h3000 (DEPTH 1024) -> done with err 1, rdata 0; subsequent read of 32'h2000 unchanged.
REQ-035 Reset mid-write: WAIT_CYCLES=2, write 32'h0 to a word holding 32'hCAFEF00D, assert rst_i in WAIT -> no done; later read returns 32'hCAFEF00D.
